uart_rx: RTL and testbench

//  Memory-mapped UART receiver; the receive-side companion to the iodev UART transmitter.

---
 rtl/uart_rx.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// Memory-mapped 8N1 UART receiver with a small receive FIFO.
// DATA register at offset 4'h4 (read pops), STATUS at 4'h5 (write-one-to-clear flags).
module uart_rx #(
   parameter int CLKS_PER_BIT = 104,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [2:0]  write_enable,
   input  logic [23:0] addr,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   input  logic        uart_rxd,
   output logic        rx_irq
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] CNT_HALF    = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_BIT_END = CW'(CLKS_PER_BIT - 1);
   localparam logic [4:0]    COUNT_FULL  = 5'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [2:0]      r_bit_idx;
   logic [7:0]      r_shift;

   logic            r_sync1;
   logic            r_sync2;
   logic            r_sync_prev;

   logic [7:0]      r_mem [FIFO_DEPTH];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [4:0]      r_count;

   logic            r_frame_err;
   logic            r_overrun;
   logic            r_rx_irq;

   logic            w_fall;
   logic            w_bit_end;
   logic            w_push;
   logic            w_stop_bad;
   logic            w_empty;
   logic            w_full;
   logic            w_sel_data;
   logic            w_sel_stat;
   logic            w_pop;
   logic            w_push_ok;
   logic            w_overrun_set;
   logic            w_wr_stat;
   logic [7:0]      w_head;
   logic [7:0]      w_status;
   logic            w_unused;

   // Idle-high reset value keeps a freshly reset synchronizer from faking a start edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1     <= 1'b1;
         r_sync2     <= 1'b1;
         r_sync_prev <= 1'b1;
      end else begin
         r_sync1     <= uart_rxd;
         r_sync2     <= r_sync1;
         r_sync_prev <= r_sync2;
      end
   end

   assign w_fall     = r_sync_prev & ~r_sync2;
   assign w_bit_end  = (r_cnt == CNT_BIT_END);
   assign w_push     = (r_state == S_STOP) & w_bit_end & r_sync2;
   assign w_stop_bad = (r_state == S_STOP) & w_bit_end & ~r_sync2;

   // NOTE: sequential state uses non-blocking assignments only, so every branch
   // below reads the pre-edge values of r_cnt and r_bit_idx.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (w_fall) r_state <= S_START;
            end
            S_START: begin
               if (r_cnt == CNT_HALF) begin
                  r_cnt <= '0;
                  if (!r_sync2) begin
                     r_bit_idx <= '0;
                     r_state   <= S_DATA;
                  end else begin
                     r_state   <= S_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  r_cnt              <= '0;
                  r_shift[r_bit_idx] <= r_sync2;
                  if (r_bit_idx == 3'd7) r_state   <= S_STOP;
                  else                   r_bit_idx <= r_bit_idx + 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (w_bit_end) begin
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_cnt   <= '0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign w_empty    = (r_count == 5'd0);
   assign w_full     = (r_count == COUNT_FULL);
   assign w_sel_data = en & (addr[3:0] == 4'h4);
   assign w_sel_stat = en & (addr[3:0] == 4'h5);
   assign w_pop      = w_sel_data & ~write_enable[2] & ~w_empty;
   assign w_wr_stat  = w_sel_stat & write_enable[2];

   // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
   assign w_push_ok     = w_push & (~w_full | w_pop);
   assign w_overrun_set = w_push & w_full & ~w_pop;

   // NOTE: the storage array carries no reset; pointers and count define validity.
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= r_shift;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + 5'(w_push_ok) - 5'(w_pop);
      end
   end

   // Sticky flags: a set in the same cycle as a clear wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
         r_rx_irq    <= 1'b0;
      end else begin
         if (w_stop_bad)                  r_frame_err <= 1'b1;
         else if (w_wr_stat & data_in[7]) r_frame_err <= 1'b0;
         if (w_overrun_set)               r_overrun   <= 1'b1;
         else if (w_wr_stat & data_in[6]) r_overrun   <= 1'b0;
         r_rx_irq <= ~w_empty | r_frame_err | r_overrun;
      end
   end

   assign w_head   = w_empty ? 8'h00 : r_mem[r_rd_ptr];
   assign w_status = {r_frame_err, r_overrun, r_count, ~w_empty};

   assign data_out = w_sel_data ? {24'b0, w_head}   :
                     w_sel_stat ? {24'b0, w_status} : 32'hzzzz_zzzz;
   assign rx_irq   = r_rx_irq;

   assign w_unused = &{1'b0, write_enable[1:0], addr[23:4], data_in[31:8], data_in[5:0]};

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit and a 4-entry FIFO.
module tb_uart_rx;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [2:0]  write_enable;
   logic [23:0] addr;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        uart_rxd;
   logic        rx_irq;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] rd;
   logic [31:0] popped;

   uart_rx #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .write_enable (write_enable),
      .addr         (addr),
      .data_in      (data_in),
      .data_out     (data_out),
      .uart_rxd     (uart_rxd),
      .rx_irq       (rx_irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
      en           = 1'b1;
      write_enable = 3'b000;
      addr         = {20'b0, a};
      #1 d = data_out;
      @(negedge clk);
      en = 1'b0;
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [31:0] v);
      en           = 1'b1;
      write_enable = 3'b100;
      addr         = {20'b0, a};
      data_in      = v;
      @(negedge clk);
      en           = 1'b0;
      write_enable = 3'b000;
   endtask

   // Optional DATA read issued pop_at negedges into the stop bit (lands on the push edge at 10).
   task automatic send_byte(input logic [7:0] b, input logic stop, input int pop_at);
      uart_rxd = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rxd = b[i];
         repeat (16) @(negedge clk);
      end
      uart_rxd = stop;
      for (int m = 1; m <= 16; m++) begin
         @(negedge clk);
         if (m == pop_at) begin
            en           = 1'b1;
            write_enable = 3'b000;
            addr         = 24'h4;
            #1 popped = data_out;
         end
         if (m == pop_at + 1) en = 1'b0;
      end
      uart_rxd = 1'b1;
      repeat (stop ? 4 : 20) @(negedge clk);
   endtask

   initial begin
      rst          = 1'b1;
      en           = 1'b0;
      write_enable = 3'b000;
      addr         = '0;
      data_in      = '0;
      uart_rxd     = 1'b1;
      popped       = '0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      check("reset_irq", {31'b0, rx_irq}, 32'h0);
      bus_read(4'h5, rd); check("reset_status", rd, 32'h00);
      bus_read(4'h4, rd); check("reset_data_empty", rd, 32'h00);

      // Single byte
      send_byte(8'h55, 1'b1, -10);
      bus_read(4'h5, rd); check("t1_status", rd, 32'h03);
      check("t1_irq_high", {31'b0, rx_irq}, 32'h1);
      bus_read(4'h4, rd); check("t1_data", rd, 32'h55);
      @(negedge clk);
      check("t1_irq_low", {31'b0, rx_irq}, 32'h0);
      bus_read(4'h5, rd); check("t1_status_after", rd, 32'h00);

      // Glitch shorter than half a bit
      uart_rxd = 1'b0;
      repeat (4) @(negedge clk);
      uart_rxd = 1'b1;
      repeat (40) @(negedge clk);
      bus_read(4'h5, rd); check("t2_status", rd, 32'h00);

      // Framing error
      send_byte(8'hA3, 1'b0, -10);
      bus_read(4'h5, rd); check("t3_status", rd, 32'h80);
      bus_read(4'h4, rd); check("t3_data_empty", rd, 32'h00);
      check("t3_irq", {31'b0, rx_irq}, 32'h1);
      bus_write(4'h4, 32'hC0);
      bus_read(4'h5, rd); check("t3_wr_data_ignored", rd, 32'h80);
      bus_write(4'h5, 32'h80);
      bus_read(4'h5, rd); check("t3_cleared", rd, 32'h00);

      // Overrun
      for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1, -10);
      bus_read(4'h5, rd); check("t4_status", rd, 32'h49);
      for (int i = 1; i <= 4; i++) begin
         bus_read(4'h4, rd); check("t4_data", rd, 32'(i));
      end
      bus_read(4'h5, rd); check("t4_status_drained", rd, 32'h40);
      bus_write(4'h5, 32'h40);
      bus_read(4'h5, rd); check("t4_cleared", rd, 32'h00);

      // Pop on the push edge of a full FIFO
      for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i), 1'b1, -10);
      bus_read(4'h5, rd); check("t5_full", rd, 32'h09);
      send_byte(8'h77, 1'b1, 10);
      check("t5_popped", popped, 32'h11);
      bus_read(4'h5, rd); check("t5_status", rd, 32'h09);
      bus_read(4'h4, rd); check("t5_d0", rd, 32'h12);
      bus_read(4'h4, rd); check("t5_d1", rd, 32'h13);
      bus_read(4'h4, rd); check("t5_d2", rd, 32'h14);
      bus_read(4'h4, rd); check("t5_d3", rd, 32'h77);

      // Reset in the middle of data bit 3
      uart_rxd = 1'b0;
      repeat (16) @(negedge clk);
      repeat (3) repeat (16) @(negedge clk);
      repeat (8) @(negedge clk);
      rst      = 1'b1;
      uart_rxd = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      bus_read(4'h5, rd); check("t6_after_reset", rd, 32'h00);
      check("t6_irq", {31'b0, rx_irq}, 32'h0);
      send_byte(8'h3C, 1'b1, -10);
      bus_read(4'h5, rd); check("t6_status", rd, 32'h03);
      bus_read(4'h4, rd); check("t6_data", rd, 32'h3C);
      bus_read(4'h5, rd); check("t6_empty", rd, 32'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
